// File: rtl/cb3_search_ctrl.sv
// cb3_search_ctrl: full nearest-neighbour scan of the 16-entry LSP codebook-3 ROM.
// One search per request. The ROM is combinational, so rom_data always reflects
// the registered rom_addr within the same cycle. Winner = lowest absolute error,
// with ties going to the lower index.
module cb3_search_ctrl #(
    parameter int N       = 32,
    parameter int AW      = 4,
    parameter int ENTRIES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  target,
    output logic [AW-1:0] rom_addr,
    input  logic [N-1:0]  rom_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] best_index,
    output logic [N-1:0]  best_value,
    output logic [N:0]    best_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRIES - 1);

    // Absolute difference of two signed N-bit words, computed at N+1 bits so
    // that no input pair can overflow.
    function automatic logic [N:0] abs_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] d;
        d = {a[N-1], a} - {b[N-1], b};
        if (d[N]) begin
            abs_diff = ~d + {{N{1'b0}}, 1'b1};
        end else begin
            abs_diff = d;
        end
    endfunction

    state_t        state_q,  state_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic [AW-1:0] idx_q,    idx_d;
    logic [N-1:0]  val_q,    val_d;
    logic [N:0]    err_q,    err_d;
    logic [N-1:0]  target_q, target_d;
    logic [N:0]    err_s;

    // Error of the entry currently presented by the ROM against the latched target.
    always_comb begin
        err_s = abs_diff(target_q, rom_data);
    end

    // Next-state logic: request acceptance, scan sequencing and running minimum.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        idx_d    = idx_q;
        val_d    = val_q;
        err_d    = err_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    target_d = target;
                    addr_d   = {AW{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = ST_SCAN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // Entry 0 seeds the minimum; later entries replace it only on a strict improvement.
                if ((addr_q == {AW{1'b0}}) || (err_s < err_q)) begin
                    idx_d = addr_q;
                    val_d = rom_data;
                    err_d = err_s;
                end else begin
                    idx_d = idx_q;
                end
                if (addr_q == LAST_ADDR) begin
                    addr_d  = {AW{1'b0}};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                // Results stay in best_* registers; start is ignored here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = {AW{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; asynchronous active-low reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= {AW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= {AW{1'b0}};
            val_q    <= {N{1'b0}};
            err_q    <= {(N+1){1'b0}};
            target_q <= {N{1'b0}};
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
            err_q    <= err_d;
            target_q <= target_d;
        end
    end

    assign rom_addr   = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign best_index = idx_q;
    assign best_value = val_q;
    assign best_err   = err_q;

endmodule
